pipe_stage_buffer: RTL and testbench

//  Parametrised elastic pipeline-stage register for the RV32I pipeline. It replaces the

---
 rtl/pipe_stage_buffer_pkg.sv | 16 +
 rtl/pipe_stage_buffer.sv | 84 ++++++++
 tb/tb_pipe_stage_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared constants and sizing helpers for the generic elastic pipeline-stage buffer.
// The IF/ID stage uses NOP_INSTR as its bubble payload. All other stages use all-zeros.
package pipe_stage_buffer_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // A pointer needs at least one bit, even when DEPTH=1.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline-stage register: a DEPTH-entry circular FIFO with a valid/ready handshake,
// stall, synchronous flush and bubble injection. The output is registered; there is no pass-through.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 2,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         stall,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam int CNT_W = cntWidth(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wrPtr;
    ptr_t             rdPtr;
    logic             push;
    logic             pop;

    // Wrap explicitly, because DEPTH need not be a power of two.
    function automatic ptr_t nextPtr(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
    endfunction

    // in_ready looks only at occupancy and the downstream side, never at in_valid.
    // A full stage still accepts an entry when its head leaves in the same cycle.
    always_comb begin
        in_ready  = (count < CNT_W'(DEPTH)) | (out_ready & ~stall);
        out_valid = (count != '0);
        out_data  = out_valid ? mem[rdPtr] : BUBBLE_VALUE;
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~stall & ~flush;
    end

    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset. A slot is only ever read after it has been
    // written, because count gates out_data, so resetting it would only add fan-out.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= in_data;
    end

    // Simulation checks: occupancy bound, and upstream holding its payload while back-pressured.
    assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
    assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: DEPTH=2 (IF/ID bubble), DEPTH=1 streaming, DEPTH=3 wrap.
module tb_pipe_stage_buffer;
    import pipe_stage_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Instance A: DEPTH=2, NOP bubble
    logic        aFlush = 0, aStall = 0, aInValid = 0, aOutReady = 0;
    logic [31:0] aInData = '0;
    logic        aInReady, aOutValid;
    logic [31:0] aOutData;
    logic [1:0]  aCount;

    // Instance B: DEPTH=1
    logic        bFlush = 0, bStall = 0, bInValid = 0, bOutReady = 0;
    logic [31:0] bInData = '0;
    logic        bInReady, bOutValid;
    logic [31:0] bOutData;
    logic [0:0]  bCount;

    // Instance C: DEPTH=3
    logic        cFlush = 0, cStall = 0, cInValid = 0, cOutReady = 0;
    logic [31:0] cInData = '0;
    logic        cInReady, cOutValid;
    logic [31:0] cOutData;
    logic [1:0]  cCount;

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(2), .BUBBLE_VALUE(NOP_INSTR)) dutA (
        .clk(clk), .rst(rst), .flush(aFlush), .stall(aStall),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .count(aCount));

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(1), .BUBBLE_VALUE(32'h0)) dutB (
        .clk(clk), .rst(rst), .flush(bFlush), .stall(bStall),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .count(bCount));

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(3), .BUBBLE_VALUE(32'h0)) dutC (
        .clk(clk), .rst(rst), .flush(cFlush), .stall(cStall),
        .in_valid(cInValid), .in_ready(cInReady), .in_data(cInData),
        .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData), .count(cCount));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        inValid;
        logic [31:0] inData;
        logic        outReady;
        logic        stall;
        logic        flush;
        logic [1:0]  expCount;
        logic        expOutValid;
        logic [31:0] expOutData;
        logic        expInReady;
    } vec_t;

    vec_t vecs[21];

    initial begin
        // Each vector applies inputs, checks pre-edge outputs, then clocks.
        // fill/drain
        vecs[0]  = '{1, 32'hA1, 0, 0, 0, 0, 0, NOP_INSTR, 1};
        vecs[1]  = '{1, 32'hB2, 0, 0, 0, 1, 1, 32'hA1,    1};
        vecs[2]  = '{0, 32'h00, 0, 0, 0, 2, 1, 32'hA1,    0};
        vecs[3]  = '{0, 32'h00, 1, 0, 0, 2, 1, 32'hA1,    1};
        vecs[4]  = '{0, 32'h00, 1, 0, 0, 1, 1, 32'hB2,    1};
        vecs[5]  = '{0, 32'h00, 1, 0, 0, 0, 0, NOP_INSTR, 1};
        // stall for three cycles with head CC
        vecs[6]  = '{1, 32'hCC, 0, 0, 0, 0, 0, NOP_INSTR, 1};
        vecs[7]  = '{1, 32'hC1, 1, 1, 0, 1, 1, 32'hCC,    1};
        vecs[8]  = '{1, 32'hC2, 1, 1, 0, 2, 1, 32'hCC,    0};
        vecs[9]  = '{1, 32'hC2, 1, 1, 0, 2, 1, 32'hCC,    0};
        vecs[10] = '{1, 32'hC2, 1, 0, 0, 2, 1, 32'hCC,    1};
        vecs[11] = '{0, 32'h00, 1, 0, 0, 2, 1, 32'hC1,    1};
        vecs[12] = '{0, 32'h00, 1, 0, 0, 1, 1, 32'hC2,    1};
        vecs[13] = '{0, 32'h00, 1, 0, 0, 0, 0, NOP_INSTR, 1};
        // flush at count=2 while DD is offered and acceptable
        vecs[14] = '{1, 32'hD1, 0, 0, 0, 0, 0, NOP_INSTR, 1};
        vecs[15] = '{1, 32'hD2, 0, 0, 0, 1, 1, 32'hD1,    1};
        vecs[16] = '{1, 32'hDD, 1, 0, 1, 2, 1, 32'hD1,    1};
        vecs[17] = '{0, 32'h00, 1, 0, 0, 0, 0, NOP_INSTR, 1};
        // flush together with stall
        vecs[18] = '{1, 32'hE1, 0, 0, 0, 0, 0, NOP_INSTR, 1};
        vecs[19] = '{1, 32'hE2, 1, 1, 1, 1, 1, 32'hE1,    1};
        vecs[20] = '{0, 32'h00, 1, 0, 0, 0, 0, NOP_INSTR, 1};

        #12 rst = 1'b0;
        step();

        for (int i = 0; i < 21; i++) begin
            aInValid  = vecs[i].inValid;
            aInData   = vecs[i].inData;
            aOutReady = vecs[i].outReady;
            aStall    = vecs[i].stall;
            aFlush    = vecs[i].flush;
            #1;
            check($sformatf("v%0d count", i),     32'(aCount),    32'(vecs[i].expCount));
            check($sformatf("v%0d out_valid", i), 32'(aOutValid), 32'(vecs[i].expOutValid));
            check($sformatf("v%0d out_data", i),  aOutData,       vecs[i].expOutData);
            check($sformatf("v%0d in_ready", i),  32'(aInReady),  32'(vecs[i].expInReady));
            step();
        end
        aInValid = 0; aOutReady = 0; aStall = 0; aFlush = 0;

        // Asynchronous reset mid-traffic, observed with no clock edge
        aInValid = 1; aInData = 32'hF1; step();
        aInData = 32'hF2; step();
        aInValid = 0;
        #1 check("rst pre count", 32'(aCount), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("rst count",     32'(aCount),    32'd0);
        check("rst out_valid", 32'(aOutValid), 32'd0);
        check("rst out_data",  aOutData,       NOP_INSTR);
        check("rst in_ready",  32'(aInReady),  32'd1);
        step();
        rst = 1'b0;
        step();

        // DEPTH=1 back-to-back streaming
        bInValid = 1; bOutReady = 1; bInData = 32'h1;
        #1 check("stream in_ready", 32'(bInReady), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("stream %0d data", i),  bOutData,       32'(i));
            check($sformatf("stream %0d valid", i), 32'(bOutValid), 32'd1);
            check($sformatf("stream %0d count", i), 32'(bCount),    32'd1);
            check($sformatf("stream %0d ready", i), 32'(bInReady),  32'd1);
            if (i < 16) bInData = 32'(i + 1);
            else        bInValid = 0;
        end
        step();
        check("stream drain count", 32'(bCount),    32'd0);
        check("stream drain valid", 32'(bOutValid), 32'd0);

        // DEPTH=3: full, push+pop together, pointer wrap
        cOutReady = 0;
        for (int v = 5; v <= 7; v++) begin
            cInValid = 1; cInData = 32'(v);
            step();
        end
        cInValid = 0;
        #1;
        check("full count",    32'(cCount),   32'd3);
        check("full in_ready", 32'(cInReady), 32'd0);
        check("full head",     cOutData,      32'd5);
        cInValid = 1; cInData = 32'd8; cOutReady = 1;
        #1 check("full+pop in_ready", 32'(cInReady), 32'd1);
        step();
        cInValid = 0;
        check("after push+pop count", 32'(cCount), 32'd3);
        for (int v = 6; v <= 8; v++) begin
            #1;
            check($sformatf("wrap data %0d", v), cOutData,       32'(v));
            check($sformatf("wrap valid %0d", v), 32'(cOutValid), 32'd1);
            step();
        end
        check("wrap empty count", 32'(cCount),    32'd0);
        check("wrap empty valid", 32'(cOutValid), 32'd0);
        check("wrap empty data",  cOutData,       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
